// File: rtl/banyan_acq_seq.sv
// Acquisition sequencer for the banyan capture memory: arbitrates host/scanner
// ownership, waits for a (delayed) trigger, then runs the memory until rollover.
module banyan_acq_seq #(
   parameter int dw_delay = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                host_arm,
   input  logic [7:0]          host_mask,
   input  logic                host_cont,
   input  logic                scan_req,
   input  logic                scan_arm,
   input  logic [7:0]          scan_mask,
   input  logic                abort,
   input  logic                trig_sel,
   input  logic                sw_trig,
   input  logic                ext_trig,
   input  logic [dw_delay-1:0] trig_delay,
   input  logic                data_valid,
   input  logic                rollover,
   output logic                mem_reset,
   output logic                mem_run,
   output logic [7:0]          mem_mask,
   output logic                scan_grant,
   output logic [2:0]          state,
   output logic                done,
   output logic                arm_dropped,
   output logic [15:0]         cap_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_DELAY = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic                owner_q;          // 1 = scanner owns the path
   logic [dw_delay-1:0] cnt_q, cnt_d;
   logic                mem_reset_q;
   logic [7:0]          mask_q;
   logic                drop_q;
   logic [15:0]         caps_q;

   logic own_arm, other_arm, trig, arm_ok, arm_drop, cap_inc;

   always_comb begin
      own_arm   = owner_q ? scan_arm : host_arm;
      other_arm = owner_q ? host_arm : scan_arm;
      trig      = trig_sel ? ext_trig : sw_trig;
      state_d   = state_q;
      cnt_d     = cnt_q;
      arm_ok    = 1'b0;
      cap_inc   = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (own_arm) begin
                  state_d = S_ARMED;
                  arm_ok  = 1'b1;
               end
            end
            S_ARMED: begin
               if (trig) begin
                  if (trig_delay == '0) begin
                     state_d = S_RUN;
                  end else begin
                     state_d = S_DELAY;
                     cnt_d   = trig_delay;
                  end
               end
            end
            S_DELAY: begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == dw_delay'(1)) state_d = S_RUN;
            end
            S_RUN: begin
               if (rollover) begin
                  state_d = S_DONE;
                  cap_inc = 1'b1;
               end
            end
            S_DONE: begin
               if (own_arm) begin
                  state_d = S_ARMED;
                  arm_ok  = 1'b1;
               end else if (!owner_q && host_cont) begin
                  state_d = S_ARMED;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      // Any arm that did not start a capture is reported, including non-owner arms.
      arm_drop = other_arm | (own_arm & ~arm_ok);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         owner_q     <= 1'b0;
         cnt_q       <= '0;
         mem_reset_q <= 1'b0;
         mask_q      <= 8'd0;
         drop_q      <= 1'b0;
         caps_q      <= 16'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_reset_q <= (state_d == S_RUN) && (state_q != S_RUN);
         if (state_q == S_IDLE || state_q == S_DONE) owner_q <= scan_req;
         if (state_q != S_RUN) mask_q <= owner_q ? scan_mask : host_mask;
         if (arm_drop)    drop_q <= 1'b1;
         else if (arm_ok) drop_q <= 1'b0;
         if (cap_inc) caps_q <= caps_q + 16'd1;
      end
   end

   // The mem_reset cycle doubles as the marker for the first RUN cycle.
   assign mem_reset   = mem_reset_q;
   assign mem_run     = (state_q == S_RUN) && !mem_reset_q && data_valid;
   assign mem_mask    = mask_q;
   assign scan_grant  = owner_q;
   assign state       = state_q;
   assign done        = (state_q == S_DONE);
   assign arm_dropped = drop_q;
   assign cap_count   = caps_q;

endmodule
